branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//  Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters per entry.
//  Looked up combinationally with the IF-stage PC; drives pred_taken/pred_target to the PC mux.
//  Trained from the MEM-stage branch resolver: upd_en, upd_pc, upd_taken, upd_target, upd_is_jump.
//  pred_taken travels down the pipe and comes back as that resolver's predictedTaken input.
// PARAMETERS
//  ENTRIES     16   number of entries; power of two, >= 2
//  INDEX_BITS  4    log2(ENTRIES); tag width = 30 - INDEX_BITS
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  fetch_pc     in   32  PC being fetched this cycle
//  pred_taken   out  1   predict taken for fetch_pc (combinational from state)
//  pred_target  out  32  predicted target; 0 when pred_taken=0
//  upd_en       in   1   resolved jump/branch in MEM this cycle (update_btb)
//  upd_pc       in   32  PC of the resolved instruction
//  upd_taken    in   1   actual outcome (jump or taken branch)
//  upd_is_jump  in   1   JAL/JALR: always taken
//  upd_target   in   32  resolved target address (jump_addr), bit0 already cleared for JALR
//  flush        in   1   invalidate all entries (e.g. fence.i)
// BEHAVIOUR
//  Addressing: idx = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; pc[1:0] ignored.
//  Entry state: valid(1), tag, target(32), ctr(2).
//    ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//  Lookup (no added latency):
//    hit = valid[idx] && tag match.
//    pred_taken = hit && ctr[1]; pred_target = pred_taken ? target : 32'h0.
//  Update (registered, applied on the rising edge when upd_en=1):
//    hit, upd_taken=1:  ctr = sat_inc(ctr); target <= upd_target.
//    hit, upd_taken=0:  ctr = sat_dec(ctr); target unchanged.
//    upd_is_jump=1:     ctr <= 2'b11 whether hit or miss; allocates on a miss.
//    miss, taken, not jump: allocate valid=1, tag, target, ctr=2'b10.
//    miss, not taken:   no change; not-taken branches are never allocated.
//    Allocation overwrites any aliasing entry at idx; there is no replacement choice.
//  Saturation: 11 + taken stays 11; 00 + not-taken stays 00; no wrap.
//  Same-cycle lookup and update to the same idx:
//    lookup returns the pre-update state; no bypass.
//  flush=1: on the next edge all valid bits clear; overrides a simultaneous upd_en.
//    Lookup in the flush cycle still sees the old state.
//  Reset (async, rst_n=0):
//    all valid=0, ctr=2'b01, target=0, tag=0.
//    pred_taken=0 and pred_target=0 immediately, including mid-operation; no update is applied.
//    After deassertion, the first update is taken at the first rising edge with rst_n=1.
//  Inputs with upd_en=0 are don't-care. X on fetch_pc must not corrupt state.
// TESTING
//  1 Cold: after reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0.
//  2 Train taken: upd_pc=0x100 taken, target 0x80 -> next cycle fetch 0x100 gives pred_taken=1, pred_target=0x80 (ctr 10).
//    A second taken update -> ctr 11.
//  3 Hysteresis: from ctr 11, one not-taken -> still predicts taken (10).
//    A second not-taken -> pred_taken=0 (01).
//    Two further not-taken -> ctr 00; then one taken -> 01, still not predicted.
//  4 Alias with ENTRIES=16:
//    train 0x100 taken, then upd 0x140 JAL target 0x200.
//    -> 0x140 predicts 0x200 (ctr 11); 0x100 misses, pred_taken=0.
//  5 Same-cycle: lookup 0x100 while first taken update to 0x100 -> pred_taken=0 that cycle, 1 the cycle after.
//    flush together with upd_en -> all entries invalid, update dropped.
//  6 Reset mid-run: assert rst_n=0 between edges with trained entries -> pred_taken drops to 0 asynchronously.
//    After release, lookups miss until retrained.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Lookup is purely combinational from fetch_pc; training comes from the MEM-stage
// branch resolver and takes effect on the next rising edge.
module branch_target_buffer #(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_is_jump,
  input  logic [31:0] upd_target,
  input  logic        flush
);

  localparam int TAG_W = 30 - INDEX_BITS;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_WEAK_NT  = 2'b01;
  localparam logic [1:0] CTR_WEAK_T   = 2'b10;
  localparam logic [1:0] CTR_STRONG_T = 2'b11;

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] w_f_idx;
  logic [TAG_W-1:0]      w_f_tag;
  logic                  w_f_hit;
  logic [INDEX_BITS-1:0] w_u_idx;
  logic [TAG_W-1:0]      w_u_tag;
  logic                  w_u_hit;
  // pc[1:0] never participate in addressing.
  logic                  w_unused_lo;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  assign w_f_idx     = fetch_pc[INDEX_BITS+1:2];
  assign w_f_tag     = fetch_pc[31:INDEX_BITS+2];
  assign w_u_idx     = upd_pc[INDEX_BITS+1:2];
  assign w_u_tag     = upd_pc[31:INDEX_BITS+2];
  assign w_unused_lo = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  // Prediction sees pre-update state; rst_n gating forces outputs low the moment reset asserts.
  assign pred_taken  = rst_n && w_f_hit && r_ctr[w_f_idx][1];
  assign pred_target = pred_taken ? r_target[w_f_idx] : 32'h0;

  // Entry training: flush beats update, jumps force strong-taken, NT misses never allocate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WEAK_NT;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (upd_en) begin
      if (w_u_hit) begin
        if (upd_is_jump) begin
          r_ctr[w_u_idx]    <= CTR_STRONG_T;
          r_target[w_u_idx] <= upd_target;
        end else if (upd_taken) begin
          r_ctr[w_u_idx]    <= sat_inc(r_ctr[w_u_idx]);
          r_target[w_u_idx] <= upd_target;
        end else begin
          r_ctr[w_u_idx]    <= sat_dec(r_ctr[w_u_idx]);
        end
      end else if (upd_is_jump || upd_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= upd_target;
        r_ctr[w_u_idx]    <= upd_is_jump ? CTR_STRONG_T : CTR_WEAK_T;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios plus a randomized run
// checked against an array-based reference model of the predictor.
module tb_branch_target_buffer;

  localparam int ENTRIES    = 16;
  localparam int INDEX_BITS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic        upd_is_jump = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        flush = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one record per slot, counter kept as an integer 0..3.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];

  branch_target_buffer #(.ENTRIES(ENTRIES), .INDEX_BITS(INDEX_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_is_jump(upd_is_jump), .upd_target(upd_target), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 32'h0; m_ctr[i] = 1;
    end
  endtask

  task automatic m_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int s;
    s  = slot_of(pc);
    t  = m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
    tg = t ? m_target[s] : 32'h0;
  endtask

  task automatic m_train();
    int s;
    bit hit;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      return;
    end
    if (!upd_en) return;
    s   = slot_of(upd_pc);
    hit = m_valid[s] && (m_tag[s] == tag_of(upd_pc));
    if (upd_is_jump) begin
      m_valid[s] = 1; m_tag[s] = tag_of(upd_pc); m_target[s] = upd_target; m_ctr[s] = 3;
    end else if (hit && upd_taken) begin
      m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3; m_target[s] = upd_target;
    end else if (hit) begin
      m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
    end else if (upd_taken) begin
      m_valid[s] = 1; m_tag[s] = tag_of(upd_pc); m_target[s] = upd_target; m_ctr[s] = 2;
    end
  endtask

  task automatic drive(input logic [31:0] fpc, input logic en, input logic [31:0] pc,
                       input logic tk, input logic jmp, input logic [31:0] tgt, input logic fl);
    fetch_pc = fpc; upd_en = en; upd_pc = pc; upd_taken = tk;
    upd_is_jump = jmp; upd_target = tgt; flush = fl;
  endtask

  // One clock: model trains on the same edge as the DUT, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) m_train();
    @(negedge clk);
    drive(fetch_pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    m_reset();
    drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_vec++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_err++; $display("FAIL reset_hold: got %b/%h want 0/00000000", pred_taken, pred_target);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_vec++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_err++; $display("FAIL cold_lookup: got %b/%h want 0/00000000", pred_taken, pred_target);
    end
  endtask

  task automatic test_train();
    @(negedge clk);
    drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    tick();
    #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_err++; $display("FAIL train_first: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
    @(negedge clk);
    drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    tick();
  endtask

  task automatic test_hysteresis();
    // ctr now 11
    drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_err++; $display("FAIL hyst_one_nt: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
    @(negedge clk);
    drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); #1;
    n_vec++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_err++; $display("FAIL hyst_two_nt: got %b/%h want 0/00000000", pred_taken, pred_target);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    // 00 + taken -> 01, still not predicted
    drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h84, 1'b0);
    tick(); #1;
    n_vec++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_err++; $display("FAIL hyst_floor: got %b/%h want 0/00000000", pred_taken, pred_target);
    end
    @(negedge clk);
    drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h88, 1'b0);
    tick(); #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h88) begin
      n_err++; $display("FAIL hyst_recover: got %b/%h want 1/00000088", pred_taken, pred_target);
    end
  endtask

  task automatic test_alias();
    @(negedge clk);
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    tick();
    drive(32'h0, 1'b1, 32'h140, 1'b1, 1'b1, 32'h200, 1'b0);
    tick();
    drive(32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      n_err++; $display("FAIL alias_new: got %b/%h want 1/00000200", pred_taken, pred_target);
    end
    fetch_pc = 32'h100; #1;
    n_vec++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_err++; $display("FAIL alias_evicted: got %b/%h want 0/00000000", pred_taken, pred_target);
    end
    // jump installs strong-taken: one not-taken still predicts taken
    drive(32'h140, 1'b1, 32'h140, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      n_err++; $display("FAIL alias_jump_strong: got %b/%h want 1/00000200", pred_taken, pred_target);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0); #1;
    n_vec++;
    if (pred_taken !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_pre: got %b want 0", pred_taken);
    end
    tick(); #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_err++; $display("FAIL same_cycle_post: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(32'h100, 1'b1, 32'h180, 1'b1, 1'b1, 32'h300, 1'b1); #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_err++; $display("FAIL flush_cycle_old: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
    tick(); #1;
    n_vec++;
    if (pred_taken !== 1'b0) begin
      n_err++; $display("FAIL flush_cleared: got %b want 0", pred_taken);
    end
    fetch_pc = 32'h180; #1;
    n_vec++;
    if (pred_taken !== 1'b0) begin
      n_err++; $display("FAIL flush_drops_upd: got %b want 0", pred_taken);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    tick();
    drive(32'h0, 1'b1, 32'h140, 1'b1, 1'b1, 32'h240, 1'b0);
    tick();
    drive(32'h140, 1'b1, 32'h100, 1'b1, 1'b0, 32'h90, 1'b0); #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin
      n_err++; $display("FAIL pre_reset: got %b/%h want 1/00000240", pred_taken, pred_target);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_err++; $display("FAIL async_reset: got %b/%h want 0/00000000", pred_taken, pred_target);
    end
    m_reset();
    tick();  // edge in reset: update must be ignored
    rst_n = 1'b1;
    fetch_pc = 32'h100; #1;
    n_vec++;
    if (pred_taken !== 1'b0) begin
      n_err++; $display("FAIL post_reset_100: got %b want 0", pred_taken);
    end
    fetch_pc = 32'h140; #1;
    n_vec++;
    if (pred_taken !== 1'b0) begin
      n_err++; $display("FAIL post_reset_140: got %b want 0", pred_taken);
    end
    drive(32'h140, 1'b1, 32'h140, 1'b1, 1'b0, 32'h44, 1'b0);
    tick(); #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h44) begin
      n_err++; $display("FAIL retrain: got %b/%h want 1/00000044", pred_taken, pred_target);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    t = 32'($urandom_range(0, 3));
    if (t == 32'd3) t = 32'h03FF_FFFF;
    return (t << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic        et;
    logic [31:0] eg;
    logic        xf;
    @(negedge clk);
    for (int n = 0; n < 600; n++) begin
      xf = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1)
        drive(rand_pc(), 1'b1, rand_pc(), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0), {$urandom, 2'b00} >> 2 << 1, ($urandom_range(0, 40) == 0));
      else
        drive(rand_pc(), 1'b0, 32'hx, 1'bx, 1'bx, 32'hx, ($urandom_range(0, 40) == 0));
      if (xf) fetch_pc = 32'hx;
      #1;
      if (!xf) begin
        m_predict(fetch_pc, et, eg);
        n_vec++;
        if (pred_taken !== et || pred_target !== eg) begin
          n_err++;
          $display("FAIL random_lookup pc=%h: got %b/%h want %b/%h", fetch_pc, pred_taken, pred_target, et, eg);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
